// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite bitmap writer: default geometry, FSM encoding, row type.
package sprite_pkg;

    localparam int ROWS_DEF  = 16;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;
    localparam int RW        = $clog2(ROWS_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_VS = 2'd2,
        COPY    = 2'd3
    } state_t;

    typedef logic [WIDTH_DEF-1:0] row_t;

endpackage

// File: rtl/sprite_bank.sv
// ROWS x WIDTH register bank: one sync write port, a renderer read port and a copy read port
// (both asynchronous), and a synchronous clear.
module sprite_bank
    import sprite_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int WIDTH = WIDTH_DEF,
    localparam int AW   = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic [AW-1:0]    caddr,
    output logic [WIDTH-1:0] cdata
);

    // One extra bit so addresses past ROWS (non power-of-two ROWS) can be rejected.
    localparam logic [AW:0] LIMIT = (AW+1)'(ROWS);

    logic [WIDTH-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < ROWS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && ({1'b0, waddr} < LIMIT)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < LIMIT) ? mem[raddr] : '0;
    assign cdata = ({1'b0, caddr} < LIMIT) ? mem[caddr] : '0;

endmodule

// File: rtl/sprite_bitmap_writer.sv
// Double-buffered sprite bitmap: row writes fill the back bank, commit swaps banks on vsync,
// then the new front is copied into the new back. Optional bit-reversal via SPRITE_FLIP_EN.
module sprite_bitmap_writer
    import sprite_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    localparam int AW   = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_row,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    input  logic             wr_flip,
    input  logic             vsync,
    input  logic [AW-1:0]    yofs,
    output logic [WIDTH-1:0] bits,
    output logic             commit_pend,
    output logic [CNT_W-1:0] commit_cnt,
    output state_t           dbg_state
);

    // Handshake: a row write transfers on a rising clk edge where wr_valid && wr_ready;
    // wr_ready depends only on state, and the source holds wr_row/wr_data while not ready.

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    state_t           state, state_nxt;
    logic             front_sel;
    logic             vsync_q;
    logic             vs_rise;
    logic             wr_fire;
    logic [AW-1:0]    copy_idx;
    logic [WIDTH-1:0] wr_row_data;
    logic             back_we;
    logic [AW-1:0]    back_addr;
    logic [WIDTH-1:0] back_data;
    logic [WIDTH-1:0] b0_rdata, b1_rdata, b0_cdata, b1_cdata;
    logic [WIDTH-1:0] copy_src;

    assign vs_rise = vsync & ~vsync_q;
    assign wr_fire = wr_valid & wr_ready;

`ifdef SPRITE_FLIP_EN
    always_comb begin
        wr_row_data = wr_data;
        if (wr_flip) begin
            for (int i = 0; i < WIDTH; i++) begin
                wr_row_data[i] = wr_data[WIDTH-1-i];
            end
        end
    end
`else
    logic unused_flip;
    assign unused_flip = wr_flip;
    assign wr_row_data = wr_data;
`endif

    always_comb begin
        state_nxt   = state;
        wr_ready    = 1'b0;
        commit_pend = 1'b0;
        case (state)
            IDLE, LOAD: begin
                wr_ready = 1'b1;
                if (wr_fire) begin
                    state_nxt = wr_last ? WAIT_VS : LOAD;
                end
            end
            WAIT_VS: begin
                commit_pend = 1'b1;
                if (vs_rise) begin
                    state_nxt = COPY;
                end
            end
            COPY: begin
                if (copy_idx == LAST_ROW) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            front_sel  <= 1'b0;
            commit_cnt <= '0;
            copy_idx   <= '0;
            vsync_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_q <= vsync;
            if (state == WAIT_VS && vs_rise) begin
                front_sel  <= ~front_sel;
                commit_cnt <= commit_cnt + 1'b1;
            end
            copy_idx <= (state == COPY && copy_idx != LAST_ROW) ? copy_idx + 1'b1 : '0;
        end
    end

    // The back bank takes either an accepted row write or the copy of the current front row.
    assign copy_src  = front_sel ? b1_cdata : b0_cdata;
    assign back_we   = wr_fire | (state == COPY);
    assign back_addr = (state == COPY) ? copy_idx : wr_row;
    assign back_data = (state == COPY) ? copy_src : wr_row_data;

    sprite_bank #(.ROWS(ROWS), .WIDTH(WIDTH)) u_bank0 (
        .clk   (clk),
        .clr   (reset),
        .we    (back_we & front_sel),
        .waddr (back_addr),
        .wdata (back_data),
        .raddr (yofs),
        .rdata (b0_rdata),
        .caddr (copy_idx),
        .cdata (b0_cdata)
    );

    sprite_bank #(.ROWS(ROWS), .WIDTH(WIDTH)) u_bank1 (
        .clk   (clk),
        .clr   (reset),
        .we    (back_we & ~front_sel),
        .waddr (back_addr),
        .wdata (back_data),
        .raddr (yofs),
        .rdata (b1_rdata),
        .caddr (copy_idx),
        .cdata (b1_cdata)
    );

    assign bits      = front_sel ? b1_rdata : b0_rdata;
    assign dbg_state = state;

endmodule
